serial_magnitude_comparator: RTL and testbench

//  Bit-serial unsigned magnitude comparator. Takes operands A and B one bit pair per

---
 rtl/serial_magnitude_comparator.sv | 94 +++++++++
 tb/tb_serial_magnitude_comparator.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/serial_magnitude_comparator.sv
// Bit-serial unsigned magnitude comparator.
// Consumes A/B one bit pair per transfer, MSB first, and reports gt/eq/lt
// with a one-cycle done pulse. The first differing bit pair decides the result.
module serial_magnitude_comparator #(
    parameter int WIDTH = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic start,
    input  logic bit_valid,
    input  logic a_bit,
    input  logic b_bit,
    output logic bit_ready,
    output logic busy,
    output logic done,
    output logic gt,
    output logic eq,
    output logic lt
);

    localparam int CW = $clog2(WIDTH + 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SHIFT = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    logic [1:0]    state;
    logic [CW-1:0] cnt;
    logic          r_gt, r_lt;
    logic          xfer, last;
    logic          nxt_gt, nxt_lt;

    assign xfer = (state == S_SHIFT) && bit_valid;
    assign last = xfer && (cnt == CW'(1));

    // Running decision: only the first differing bit pair may set a flag.
    always_comb begin
        nxt_gt = r_gt;
        nxt_lt = r_lt;
        if (!r_gt && !r_lt) begin
            nxt_gt = a_bit & ~b_bit;
            nxt_lt = ~a_bit & b_bit;
        end
    end

    // Control FSM, bit counter and decision flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
            cnt   <= '0;
            r_gt  <= 1'b0;
            r_lt  <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state <= S_SHIFT;
                        cnt   <= CW'(WIDTH);
                        r_gt  <= 1'b0;
                        r_lt  <= 1'b0;
                    end
                end
                S_SHIFT: begin
                    if (xfer) begin
                        r_gt <= nxt_gt;
                        r_lt <= nxt_lt;
                        cnt  <= cnt - CW'(1);
                        if (last) state <= S_DONE;
                    end
                end
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    // Result registers load on the final transfer so they change together with done.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gt <= 1'b0;
            eq <= 1'b0;
            lt <= 1'b0;
        end else if (last) begin
            gt <= nxt_gt;
            lt <= nxt_lt;
            eq <= ~nxt_gt & ~nxt_lt;
        end
    end

    assign bit_ready = (state == S_SHIFT);
    assign busy      = (state == S_SHIFT) || (state == S_DONE);
    assign done      = (state == S_DONE);

endmodule

// File: tb/tb_serial_magnitude_comparator.sv
// Self-checking bench: index 0 is a WIDTH=4 instance, index 1 a WIDTH=2 instance.
module tb_serial_magnitude_comparator;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic st[2], bv[2], ab[2], bb[2];
    logic rdy[2], bsy[2], dn[2], g[2], e[2], l[2];
    logic pg[2], pe[2], pl[2];
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    serial_magnitude_comparator #(.WIDTH(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .start(st[0]), .bit_valid(bv[0]),
        .a_bit(ab[0]), .b_bit(bb[0]), .bit_ready(rdy[0]), .busy(bsy[0]),
        .done(dn[0]), .gt(g[0]), .eq(e[0]), .lt(l[0]));

    serial_magnitude_comparator #(.WIDTH(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .start(st[1]), .bit_valid(bv[1]),
        .a_bit(ab[1]), .b_bit(bb[1]), .bit_ready(rdy[1]), .busy(bsy[1]),
        .done(dn[1]), .gt(g[1]), .eq(e[1]), .lt(l[1]));

    typedef struct {
        logic [3:0] a, b;
        int         stall_pos, stall_n;
        bit         poke;
        logic       xg, xe, xl;
    } vec_t;

    task automatic chk(input string nm, input logic got, input logic exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0b exp=%0b", nm, got, exp);
        end
    endtask

    task automatic chki(input string nm, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got=%0d exp=%0d", nm, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_held(input int d, input string nm);
        chk({nm, " gt held"}, g[d], pg[d]);
        chk({nm, " eq held"}, e[d], pe[d]);
        chk({nm, " lt held"}, l[d], pl[d]);
    endtask

    // One full compare on instance d of width w; stall_n idle cycles inserted
    // before bit index stall_pos (0 = MSB). poke adds stray start/bit_valid.
    task automatic compare(input int d, input int w, input logic [3:0] a, input logic [3:0] b,
                           input int stall_pos, input int stall_n, input bit poke,
                           input logic xg, input logic xe, input logic xl, input string nm);
        int lat;
        int exp_lat;
        if (poke) begin
            st[d] = 1'b0; bv[d] = 1'b1; ab[d] = 1'b1; bb[d] = 1'b0;
            tick();
            chk({nm, " idle valid ignored busy"}, bsy[d], 1'b0);
            chk_held(d, {nm, " idle"});
        end
        chk({nm, " ready low at start"}, rdy[d], 1'b0);
        st[d] = 1'b1; bv[d] = poke;
        tick();
        lat = 1;
        st[d] = 1'b0;
        chk({nm, " busy"}, bsy[d], 1'b1);
        for (int k = 0; k < w; k++) begin
            if (k == stall_pos) begin
                for (int s = 0; s < stall_n; s++) begin
                    bv[d] = 1'b0;
                    chk({nm, " stall ready"}, rdy[d], 1'b1);
                    chk({nm, " stall no done"}, dn[d], 1'b0);
                    tick();
                    lat++;
                end
            end
            bv[d] = 1'b1; ab[d] = a[w-1-k]; bb[d] = b[w-1-k];
            if (poke && k == 1) st[d] = 1'b1;
            chk({nm, " shift ready"}, rdy[d], 1'b1);
            chk({nm, " shift no done"}, dn[d], 1'b0);
            chk_held(d, {nm, " shift"});
            tick();
            lat++;
            st[d] = 1'b0;
        end
        exp_lat = w + 1 + ((stall_pos < w) ? stall_n : 0);
        bv[d] = 1'b0;
        chk({nm, " done"}, dn[d], 1'b1);
        chk({nm, " done busy"}, bsy[d], 1'b1);
        chk({nm, " done ready"}, rdy[d], 1'b0);
        chki({nm, " latency"}, lat, exp_lat);
        chk({nm, " gt"}, g[d], xg);
        chk({nm, " eq"}, e[d], xe);
        chk({nm, " lt"}, l[d], xl);
        pg[d] = xg; pe[d] = xe; pl[d] = xl;
        if (poke) begin
            st[d] = 1'b1; bv[d] = 1'b1;
        end
        tick();
        st[d] = 1'b0; bv[d] = 1'b0;
        chk({nm, " post done"}, dn[d], 1'b0);
        chk({nm, " post busy"}, bsy[d], 1'b0);
        chk({nm, " post ready"}, rdy[d], 1'b0);
        chk_held(d, {nm, " post"});
    endtask

    vec_t tbl[9];

    initial begin
        for (int d = 0; d < 2; d++) begin
            st[d] = 0; bv[d] = 0; ab[d] = 0; bb[d] = 0;
            pg[d] = 0; pe[d] = 0; pl[d] = 0;
        end
        tbl[0] = '{4'b1001, 4'b1001, 9, 0, 1'b0, 1'b0, 1'b1, 1'b0};
        tbl[1] = '{4'b0111, 4'b1000, 2, 3, 1'b0, 1'b0, 1'b0, 1'b1};
        tbl[2] = '{4'b1010, 4'b0110, 1, 1, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[3] = '{4'd3,    4'd5,    9, 0, 1'b0, 1'b0, 1'b0, 1'b1};
        tbl[4] = '{4'd5,    4'd3,    9, 0, 1'b0, 1'b1, 1'b0, 1'b0};
        tbl[5] = '{4'b1111, 4'b0000, 0, 2, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[6] = '{4'b0000, 4'b0000, 3, 1, 1'b0, 1'b0, 1'b1, 1'b0};
        tbl[7] = '{4'b0000, 4'b1111, 9, 0, 1'b1, 1'b0, 1'b0, 1'b1};
        tbl[8] = '{4'b1110, 4'b1111, 9, 0, 1'b0, 1'b0, 1'b0, 1'b1};

        // Reset state
        #12;
        chk("rst ready", rdy[0], 1'b0);
        chk("rst busy", bsy[0], 1'b0);
        chk("rst done", dn[0], 1'b0);
        chk_held(0, "rst");
        chk_held(1, "rst w2");
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Directed table on the WIDTH=4 instance
        foreach (tbl[i])
            compare(0, 4, tbl[i].a, tbl[i].b, tbl[i].stall_pos, tbl[i].stall_n,
                    tbl[i].poke, tbl[i].xg, tbl[i].xe, tbl[i].xl,
                    $sformatf("vec%0d", i));

        // Randomized compares against plain arithmetic
        for (int i = 0; i < 25; i++) begin
            logic [3:0] ra, rb;
            ra = 4'($urandom);
            rb = (i % 4 == 0) ? ra : 4'($urandom);
            compare(0, 4, ra, rb, int'($urandom_range(0, 5)), int'($urandom_range(0, 3)),
                    bit'($urandom_range(0, 1)), ra > rb, ra == rb, ra < rb,
                    $sformatf("rnd%0d", i));
        end

        // Exhaustive WIDTH=2
        for (int a = 0; a < 4; a++)
            for (int b = 0; b < 4; b++)
                compare(1, 2, 4'(a), 4'(b), 9, 0, 1'b0, a > b, a == b, a < b,
                        $sformatf("w2 %0d/%0d", a, b));

        // Asynchronous reset in the middle of a compare
        st[0] = 1'b1;
        tick();
        st[0] = 1'b0;
        for (int k = 0; k < 2; k++) begin
            bv[0] = 1'b1; ab[0] = 1'b1; bb[0] = 1'b0;
            tick();
        end
        bv[0] = 1'b0;
        #3;
        rst_n = 1'b0;
        #1;
        pg[0] = 0; pe[0] = 0; pl[0] = 0;
        pg[1] = 0; pe[1] = 0; pl[1] = 0;
        chk("async rst busy", bsy[0], 1'b0);
        chk("async rst ready", rdy[0], 1'b0);
        chk("async rst done", dn[0], 1'b0);
        chk_held(0, "async rst");
        chk_held(1, "async rst w2");
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            bv[0] = 1'b1;
            tick();
            chk("after rst no done", dn[0], 1'b0);
            chk("after rst idle", bsy[0], 1'b0);
        end
        bv[0] = 1'b0;
        compare(0, 4, 4'b1100, 4'b1011, 9, 0, 1'b0, 1'b1, 1'b0, 1'b0, "post rst");
        compare(1, 2, 4'b0001, 4'b0011, 9, 0, 1'b0, 1'b0, 1'b0, 1'b1, "post rst w2");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
